// File: rtl/frame_writer.sv
//==============================================================================
// Module      : frame_writer
// Description : Sink of the shared VGA pixel bus. Range-checks incoming pixel
//               writes, queues {linear address, RGB} in a small FIFO and
//               commits one entry per cycle to the frame-buffer write port.
//               Optional clear engine (macro FRAME_WRITER_CLEAR_EN) fills the
//               whole frame with one colour between scenes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module frame_writer #(
   parameter int FIFO_DEPTH = 4,
   parameter int SCREEN_W   = 160,
   parameter int SCREEN_H   = 120
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vga_draw_enable_bus,
   input  logic [7:0]  vga_x_out_bus,
   input  logic [7:0]  vga_y_out_bus,
   input  logic [23:0] vga_RGB_out_bus,
   input  logic        clear,
   input  logic [23:0] clear_color,
   output logic [14:0] fb_address,
   output logic [23:0] fb_data,
   output logic        fb_write,
   output logic        busy,
   output logic        clear_done,
   output logic        overflow,
   output logic        oob_error
);

   localparam int          c_AW       = $clog2(FIFO_DEPTH);
   localparam logic [8:0]  c_W9       = 9'(SCREEN_W);
   localparam logic [8:0]  c_H9       = 9'(SCREEN_H);
   localparam logic [14:0] c_W15      = 15'(SCREEN_W);
   localparam logic [14:0] c_LAST     = 15'(SCREEN_W * SCREEN_H - 1);
   localparam logic [c_AW:0] c_PTR_ONE = (c_AW + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t r_state, w_state_next;

   // FIFO storage and pointers (extra MSB distinguishes full from empty)
   logic [38:0]   r_mem [FIFO_DEPTH];
   logic [c_AW:0] r_wr_ptr, r_rd_ptr;
   logic [c_AW:0] w_wr_ptr_next, w_rd_ptr_next;

   logic          w_valid, w_in_range, w_empty, w_full;
   logic          w_push, w_pop, w_drop;
   logic [14:0]   w_addr;
   logic          w_wr_en, w_done, w_pending_next;
   logic [14:0]   w_wr_addr;
   logic [23:0]   w_wr_data;

   assign w_valid    = (vga_draw_enable_bus == 1'b1);
   assign w_in_range = ({1'b0, vga_x_out_bus} < c_W9) && ({1'b0, vga_y_out_bus} < c_H9);
   assign w_addr     = 15'(vga_y_out_bus) * c_W15 + 15'(vga_x_out_bus);

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

   // A full FIFO still accepts a push when an entry leaves on the same edge
   assign w_push = w_valid && w_in_range && (!w_full || w_pop);
   assign w_drop = w_valid && w_in_range && w_full && !w_pop;

   assign w_wr_ptr_next = w_push ? r_wr_ptr + c_PTR_ONE : r_wr_ptr;
   assign w_rd_ptr_next = w_pop  ? r_rd_ptr + c_PTR_ONE : r_rd_ptr;

`ifdef FRAME_WRITER_CLEAR_EN
   logic        r_clear_pending;
   logic [23:0] r_clear_color;
   logic [14:0] r_clear_cnt;

   // A clear request during S_CLEAR is ignored; a new request wins over consumption
   assign w_pending_next = (clear && (r_state != S_CLEAR)) ? 1'b1 :
                           ((r_state == S_IDLE) && (w_state_next == S_CLEAR)) ? 1'b0 :
                           r_clear_pending;

   // Clear request latch, fill colour and address counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clear_pending <= 1'b0;
         r_clear_color   <= 24'd0;
         r_clear_cnt     <= 15'd0;
      end else begin
         r_clear_pending <= w_pending_next;
         if (clear && (r_state != S_CLEAR))
            r_clear_color <= clear_color;
         if ((r_state == S_IDLE) && (w_state_next == S_CLEAR))
            r_clear_cnt <= 15'd0;
         else if (r_state == S_CLEAR)
            r_clear_cnt <= r_clear_cnt + 15'd1;
      end
   end
`else
   logic w_unused_clear;
   assign w_unused_clear = ^{clear, clear_color};
   assign w_pending_next = 1'b0;
`endif

   // Next-state and write-port selection; queued pixels drain before a clear
   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_wr_en      = 1'b0;
      w_wr_addr    = 15'd0;
      w_wr_data    = 24'd0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop                  = 1'b1;
               w_wr_en                = 1'b1;
               {w_wr_addr, w_wr_data} = r_mem[r_rd_ptr[c_AW-1:0]];
            end
`ifdef FRAME_WRITER_CLEAR_EN
            else if (r_clear_pending) begin
               w_state_next = S_CLEAR;
            end
`endif
         end
`ifdef FRAME_WRITER_CLEAR_EN
         S_CLEAR: begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_clear_cnt;
            w_wr_data = r_clear_color;
            if (r_clear_cnt == c_LAST)
               w_state_next = S_DONE;
         end
         S_DONE: begin
            w_done       = 1'b1;
            w_state_next = S_IDLE;
         end
`endif
         default: w_state_next = S_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   // FIFO pointers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_wr_ptr <= w_wr_ptr_next;
         r_rd_ptr <= w_rd_ptr_next;
      end
   end

   // FIFO storage; contents are don't-care while the pointers say empty
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr[c_AW-1:0]] <= {w_addr, vga_RGB_out_bus};
   end

   // Registered outputs; busy also covers the cycle the final write is on the port
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fb_address <= 15'd0;
         fb_data    <= 24'd0;
         fb_write   <= 1'b0;
         busy       <= 1'b0;
         clear_done <= 1'b0;
         overflow   <= 1'b0;
         oob_error  <= 1'b0;
      end else begin
         fb_write   <= w_wr_en;
         if (w_wr_en) begin
            fb_address <= w_wr_addr;
            fb_data    <= w_wr_data;
         end
         busy       <= (w_wr_ptr_next != w_rd_ptr_next) || w_wr_en || w_pending_next ||
                       (w_state_next != S_IDLE);
         clear_done <= w_done;
         oob_error  <= w_valid && !w_in_range;
         if (w_drop)
            overflow <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_frame_writer.sv
//==============================================================================
// Module      : tb_frame_writer
// Description : Directed, table-driven bench for frame_writer. Clear-engine
//               sequences are exercised when FRAME_WRITER_CLEAR_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_frame_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [7:0]  x, y;
   logic [23:0] rgb;
   logic        clear;
   logic [23:0] clear_color;
   logic [14:0] fb_address;
   logic [23:0] fb_data;
   logic        fb_write, busy, clear_done, overflow, oob_error;

   frame_writer #(.FIFO_DEPTH(4), .SCREEN_W(160), .SCREEN_H(120)) dut (
      .clk                 (clk),
      .reset               (reset),
      .vga_draw_enable_bus (en),
      .vga_x_out_bus       (x),
      .vga_y_out_bus       (y),
      .vga_RGB_out_bus     (rgb),
      .clear               (clear),
      .clear_color         (clear_color),
      .fb_address          (fb_address),
      .fb_data             (fb_data),
      .fb_write            (fb_write),
      .busy                (busy),
      .clear_done          (clear_done),
      .overflow            (overflow),
      .oob_error           (oob_error)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [7:0]  x;
      logic [7:0]  y;
      logic [23:0] rgb;
      logic        oob;
      logic [14:0] addr;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_addr"},  32'(fb_address), 32'd0);
      chk({tag, "_data"},  32'(fb_data),    32'd0);
      chk({tag, "_write"}, 32'(fb_write),   32'd0);
      chk({tag, "_busy"},  32'(busy),       32'd0);
      chk({tag, "_done"},  32'(clear_done), 32'd0);
      chk({tag, "_ovf"},   32'(overflow),   32'd0);
      chk({tag, "_oob"},   32'(oob_error),  32'd0);
   endtask

   // Single pixel through an idle, empty writer: write visible after edge k+1 only
   task automatic single_pixel(input string tag, input logic [7:0] px, input logic [7:0] py,
                               input logic [23:0] pc, input logic exp_oob, input logic [14:0] exp_addr);
      en = 1'b1; x = px; y = py; rgb = pc;
      tick;
      en = 1'b0;
      chk({tag, "_oob_pulse"}, 32'(oob_error), 32'(exp_oob));
      chk({tag, "_no_early_wr"}, 32'(fb_write), 32'd0);
      chk({tag, "_busy_rise"}, 32'(busy), 32'(!exp_oob));
      tick;
      chk({tag, "_wr"}, 32'(fb_write), 32'(!exp_oob));
      if (!exp_oob) begin
         chk({tag, "_addr"}, 32'(fb_address), 32'(exp_addr));
         chk({tag, "_data"}, 32'(fb_data), 32'(pc));
      end
      chk({tag, "_oob_one_cycle"}, 32'(oob_error), 32'd0);
      tick;
      chk({tag, "_wr_once"}, 32'(fb_write), 32'd0);
      chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int n_wr;
      int seq_bad;
      logic [14:0] got_a [4];
      logic [23:0] got_d [4];
      logic [14:0] exp_a [4];
      logic [23:0] exp_d [4];

      vecs[0] = '{x:8'd5,   y:8'd2,   rgb:24'hFF0000, oob:1'b0, addr:15'd325};
      vecs[1] = '{x:8'd159, y:8'd119, rgb:24'h0000FF, oob:1'b0, addr:15'd19199};
      vecs[2] = '{x:8'd0,   y:8'd0,   rgb:24'h123456, oob:1'b0, addr:15'd0};
      vecs[3] = '{x:8'd160, y:8'd0,   rgb:24'hABCDEF, oob:1'b1, addr:15'd0};
      vecs[4] = '{x:8'd0,   y:8'd120, rgb:24'h111111, oob:1'b1, addr:15'd0};
      vecs[5] = '{x:8'd10,  y:8'd100, rgb:24'h00FF00, oob:1'b0, addr:15'd16010};
      vecs[6] = '{x:8'd255, y:8'd255, rgb:24'h222222, oob:1'b1, addr:15'd0};

      reset = 1'b1; en = 1'b0; x = 8'd0; y = 8'd0; rgb = 24'd0;
      clear = 1'b0; clear_color = 24'd0;
      repeat (2) tick;
      check_all_zero("reset");
      #4 reset = 1'b0;
      tick;

      for (int i = 0; i < 7; i++)
         single_pixel("vec", vecs[i].x, vecs[i].y, vecs[i].rgb, vecs[i].oob, vecs[i].addr);

      // Back-to-back pixels: one write per cycle, in order
      exp_a = '{15'd0, 15'd481, 15'd19198, 15'd0};
      for (int c = 0; c < 5; c++) begin
         en  = (c < 3);
         x   = (c == 0) ? 8'd0 : (c == 1) ? 8'd1 : 8'd158;
         y   = (c == 0) ? 8'd0 : (c == 1) ? 8'd3 : 8'd119;
         rgb = 24'hC00000 + 24'(c);
         tick;
         if (c >= 1 && c <= 3) begin
            chk("b2b_wr", 32'(fb_write), 32'd1);
            chk("b2b_addr", 32'(fb_address), 32'(exp_a[c-1]));
            chk("b2b_data", 32'(fb_data), 32'(24'hC00000 + 24'(c - 1)));
         end
      end
      en = 1'b0;
      tick;
      chk("b2b_idle", 32'(fb_write), 32'd0);
      chk("b2b_no_ovf", 32'(overflow), 32'd0);

`ifdef FRAME_WRITER_CLEAR_EN
      // Full-frame clear
      clear_color = 24'h00FF00; clear = 1'b1;
      tick;
      clear = 1'b0; clear_color = 24'h777777;
      chk("clr_busy", 32'(busy), 32'd1);
      chk("clr_k0_wr", 32'(fb_write), 32'd0);
      tick;
      chk("clr_k1_wr", 32'(fb_write), 32'd0);
      tick;
      chk("clr_first_wr", 32'(fb_write), 32'd1);
      chk("clr_first_addr", 32'(fb_address), 32'd0);
      chk("clr_first_data", 32'(fb_data), 32'h00FF00);
      n_wr = 1; seq_bad = 0; cyc = 0;
      while (clear_done !== 1'b1 && cyc < 20000) begin
         tick;
         cyc++;
         if (fb_write) begin
            if (fb_address !== 15'(n_wr) || fb_data !== 24'h00FF00) seq_bad++;
            n_wr++;
         end
      end
      chk("clr_done_seen", 32'(clear_done), 32'd1);
      chk("clr_write_count", 32'(n_wr), 32'd19200);
      chk("clr_seq_errors", 32'(seq_bad), 32'd0);
      tick;
      chk("clr_done_pulse", 32'(clear_done), 32'd0);
      chk("clr_busy_low", 32'(busy), 32'd0);

      // Overflow: drain held by a running clear, six pixels into four slots
      clear_color = 24'h123456; clear = 1'b1;
      tick;
      clear = 1'b0;
      repeat (2) tick;
      for (int i = 0; i < 6; i++) begin
         en = 1'b1; x = 8'(i); y = 8'd1; rgb = 24'hA00000 + 24'(i);
         tick;
         if (i == 3) chk("ovf_not_yet", 32'(overflow), 32'd0);
         if (i == 4) chk("ovf_set", 32'(overflow), 32'd1);
      end
      en = 1'b0;
      cyc = 0;
      while (clear_done !== 1'b1 && cyc < 20000) begin
         tick;
         cyc++;
      end
      chk("ovf_clr_done", 32'(clear_done), 32'd1);
      n_wr = 0;
      for (int c = 0; c < 10; c++) begin
         tick;
         if (fb_write) begin
            if (n_wr < 4) begin
               chk("ovf_q_addr", 32'(fb_address), 32'(160 + n_wr));
               chk("ovf_q_data", 32'(fb_data), 32'(24'hA00000 + 24'(n_wr)));
            end
            n_wr++;
         end
      end
      chk("ovf_q_count", 32'(n_wr), 32'd4);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      #2 reset = 1'b1;
      #1 chk("ovf_reset_clears", 32'(overflow), 32'd0);
      #2 reset = 1'b0;
      tick;

      // Queued pixels drain before the pending clear starts
      exp_a = '{15'd1, 15'd2, 15'd3, 15'd0};
      exp_d = '{24'hB00001, 24'hB00002, 24'hB00003, 24'h0000FF};
      n_wr = 0;
      for (int c = 0; c < 12; c++) begin
         en = (c < 3); x = 8'(c + 1); y = 8'd0; rgb = 24'hB00000 + 24'(c + 1);
         clear = (c == 0); clear_color = 24'h0000FF;
         tick;
         if (fb_write && n_wr < 4) begin
            got_a[n_wr] = fb_address;
            got_d[n_wr] = fb_data;
            n_wr++;
         end
      end
      en = 1'b0; clear = 1'b0;
      chk("ord_count", 32'(n_wr), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("ord_addr", 32'(got_a[i]), 32'(exp_a[i]));
         chk("ord_data", 32'(got_d[i]), 32'(exp_d[i]));
      end
      cyc = 0;
      while (clear_done !== 1'b1 && cyc < 20000) begin
         tick;
         cyc++;
      end
      chk("ord_clr_done", 32'(clear_done), 32'd1);
      tick;

      // Reset in the middle of a clear
      clear_color = 24'hFFFFFF; clear = 1'b1;
      tick;
      clear = 1'b0;
      cyc = 0;
      while (!(fb_write === 1'b1 && fb_address === 15'd500) && cyc < 1000) begin
         tick;
         cyc++;
      end
      chk("rst_mid_reached_500", 32'(fb_address), 32'd500);
      #2 reset = 1'b1;
      #1 check_all_zero("rst_mid");
      #1 reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick;
         chk("rst_mid_no_resume", 32'(fb_write), 32'd0);
      end
      single_pixel("post_rst", 8'd7, 8'd3, 24'h5A5A5A, 1'b0, 15'd487);
`else
      // Clear engine absent: clear requests have no effect
      clear_color = 24'h00FF00; clear = 1'b1;
      tick;
      clear = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk("noclr_wr", 32'(fb_write), 32'd0);
         chk("noclr_done", 32'(clear_done), 32'd0);
         chk("noclr_busy", 32'(busy), 32'd0);
         tick;
      end
      single_pixel("noclr_px", 8'd7, 8'd3, 24'h5A5A5A, 1'b0, 15'd487);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
